vector_condition_unit: RTL

Parametrised execute-stage condition unit for the pipelined core. It holds one NZCV flag register per vector lane and decodes the full 4-bit condition field against each lane's stored flags. It gates per-lane register and memory writes, resolves branches under a configurable lane-reduction mode, and registers all gated controls into the E→M pipeline boundary with stall and flush support.

---
 rtl/cond_pkg.sv | 37 +++
 rtl/cond_eval.sv | 45 ++++
 rtl/vector_condition_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the vector condition unit.
//   cond_e        : ARM 4-bit condition field encodings (EQ .. NV)
//   FLAG_*        : bit positions of N, Z, C, V inside one lane's NZCV nibble
//   branch_mode_e : lane-reduction policy for branch resolution
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        BM_LANE0 = 2'd0,
        BM_ANY   = 2'd1,
        BM_ALL   = 2'd2
    } branch_mode_e;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational ARM condition evaluator for one lane.
//   cond : 4-bit condition field
//   nzcv : the lane's stored flags {N,Z,C,V}
//   pass : 1 when the condition holds for these flags
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/vector_condition_unit.sv
// Execute-stage condition unit for a LANES-wide vector core.
// Holds one NZCV register per lane, evaluates the condition field against
// each lane's stored flags, gates per-lane writes, resolves branches with a
// selectable lane reduction and registers gated controls into the M stage.
//   clk, reset          : clock, asynchronous active-low reset
//   StallE, FlushE      : hold / kill the E instruction (both give an M bubble)
//   ValidE, CondE       : instruction valid, condition field
//   ALUFlags            : per-lane NZCV from the ALU, lane i at [4i+3:4i]
//   FlagWriteE          : [1] update N,Z ; [0] update C,V
//   LaneMaskE           : lanes participating in this instruction
//   PCSrcE, BranchE     : scalar decode controls
//   RegWriteE, MemWriteE: write requests, replicated per lane
//   CondExE, BranchTakenE : combinational per-lane pass / branch taken
//   ALUFlags_Out        : stored flag registers
//   PCSrcM, RegWriteM, MemWriteM : registered M-stage controls
module vector_condition_unit
    import cond_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int BRANCH_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidE,
    input  logic [3:0]           CondE,
    input  logic [4*LANES-1:0]   ALUFlags,
    input  logic [1:0]           FlagWriteE,
    input  logic [LANES-1:0]     LaneMaskE,
    input  logic                 PCSrcE,
    input  logic                 BranchE,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    output logic [LANES-1:0]     CondExE,
    output logic                 BranchTakenE,
    output logic [4*LANES-1:0]   ALUFlags_Out,
    output logic                 PCSrcM,
    output logic [LANES-1:0]     RegWriteM,
    output logic [LANES-1:0]     MemWriteM
);

    localparam branch_mode_e MODE = branch_mode_e'(BRANCH_MODE[1:0]);

    logic [4*LANES-1:0] flags_q;
    logic [LANES-1:0]   lane_pass;
    logic               go;
    logic               branch_r;

    // Stall and flush both freeze the flags and inject a bubble; a stalled
    // instruction simply re-evaluates next cycle against the same flags.
    assign go = !StallE && !FlushE;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        cond_eval u_eval (
            .cond (CondE),
            .nzcv (flags_q[4*gi +: 4]),
            .pass (lane_pass[gi])
        );
    end

    assign CondExE = lane_pass & LaneMaskE & {LANES{ValidE}};

    // Lane reduction. In ALL mode inactive lanes are ignored, but at least one
    // lane must be active so an empty mask never takes a branch.
    always_comb begin
        branch_r = 1'b0;
        case (MODE)
            BM_LANE0: branch_r = CondExE[0];
            BM_ANY:   branch_r = |CondExE;
            BM_ALL:   branch_r = (&(CondExE | ~LaneMaskE)) && (|LaneMaskE);
            default:  branch_r = 1'b0;
        endcase
    end

    assign BranchTakenE = BranchE && branch_r && go;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the flag file is a handful of flops, not a RAM, so it is reset with
    // the rest of the state and the combinational outputs start from zero flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (go) begin
            for (int i = 0; i < LANES; i++) begin
                if (FlagWriteE[1] && CondExE[i]) begin
                    flags_q[4*i + FLAG_N] <= ALUFlags[4*i + FLAG_N];
                    flags_q[4*i + FLAG_Z] <= ALUFlags[4*i + FLAG_Z];
                end
                if (FlagWriteE[0] && CondExE[i]) begin
                    flags_q[4*i + FLAG_C] <= ALUFlags[4*i + FLAG_C];
                    flags_q[4*i + FLAG_V] <= ALUFlags[4*i + FLAG_V];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCSrcM    <= 1'b0;
            RegWriteM <= '0;
            MemWriteM <= '0;
        end else if (go) begin
            PCSrcM    <= PCSrcE && branch_r;
            RegWriteM <= {LANES{RegWriteE}} & CondExE;
            MemWriteM <= {LANES{MemWriteE}} & CondExE;
        end else begin
            PCSrcM    <= 1'b0;
            RegWriteM <= '0;
            MemWriteM <= '0;
        end
    end

    assign ALUFlags_Out = flags_q;

endmodule
